// File: rtl/mips_mc_core.sv
// Multi-cycle 16-bit-instruction MIPS core: FETCH/DECODE/EXEC/MEM/WB with
// req/ack instruction and data memory ports, HALT and a retire pulse.
module mips_mc_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 13
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [15:0]       current_instr,
  output logic [PC_W-1:0]   PC_current,
  output logic              retired,
  output logic              halted
);

  localparam int unsigned IMM_W = 7;
  localparam int unsigned REG_N = 8;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_J    = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_SLT = 4'd4;
  localparam logic [3:0] F_JR  = 4'd5;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   npc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] rf [REG_N];

  logic [2:0]        op;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [2:0]        rd;
  logic [3:0]        funct;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   imm_pc;
  logic [PC_W-1:0]   target;
  logic [DATA_W-1:0] alu_c;
  logic              wr_en;
  logic [2:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;

  assign op      = ir[15:13];
  assign rs      = ir[12:10];
  assign rt      = ir[9:7];
  assign rd      = ir[6:4];
  assign funct   = ir[3:0];
  assign imm_ext = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign imm_pc  = imm_ext[PC_W-1:0];
  assign target  = ir[PC_W-1:0];

  assign imem_addr     = pc;
  assign PC_current    = pc;
  assign current_instr = ir;
  assign dmem_addr     = alu;
  assign dmem_wdata    = b;

  // ALU: R-type ops, effective address / addi sum, jal link value
  always_comb begin
    alu_c = '0;
    case (op)
      OP_R: begin
        case (funct)
          F_ADD:   alu_c = a + b;
          F_SUB:   alu_c = a - b;
          F_AND:   alu_c = a & b;
          F_OR:    alu_c = a | b;
          F_SLT:   alu_c = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
          default: alu_c = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_c = a + imm_ext;
      OP_JAL:  alu_c = DATA_W'(npc);
      default: alu_c = '0;
    endcase
  end

  // Write-back destination and data selection
  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = 3'd0;
    wr_data = alu;
    case (op)
      OP_R: begin
        if (funct <= F_SLT) begin
          wr_en  = 1'b1;
          wr_sel = rd;
        end
      end
      OP_ADDI: begin
        wr_en  = 1'b1;
        wr_sel = rt;
      end
      OP_LW: begin
        wr_en   = 1'b1;
        wr_sel  = rt;
        wr_data = mdr;
      end
      OP_JAL: begin
        wr_en  = 1'b1;
        wr_sel = 3'd7;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Control FSM, datapath registers and register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      npc      <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu      <= '0;
      mdr      <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      retired  <= 1'b0;
      halted   <= 1'b0;
      for (int i = 0; i < int'(REG_N); i++) rf[i] <= '0;
    end else begin
      retired <= 1'b0;
      case (state)
        S_FETCH: begin
          // First cycle out of reset raises the request; later entries arrive with it set.
          if (imem_req && imem_ack) begin
            ir       <= imem_rdata;
            npc      <= pc + PC_W'(1);
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          a     <= rf[rs];
          b     <= rf[rt];
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu <= alu_c;
          if (op == OP_BEQ || op == OP_J || (op == OP_R && funct == F_JR)) begin
            if (op == OP_BEQ) pc <= (a == b) ? npc + imm_pc : npc;
            else if (op == OP_J) pc <= target;
            else pc <= a[PC_W-1:0];
            retired  <= 1'b1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else if (op == OP_HALT) begin
            retired <= 1'b1;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else if (op == OP_LW || op == OP_SW) begin
            dmem_req <= 1'b1;
            dmem_we  <= (op == OP_SW);
            state    <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_req && dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (op == OP_LW) begin
              mdr   <= dmem_rdata;
              state <= S_WB;
            end else begin
              pc       <= npc;
              retired  <= 1'b1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (wr_en && wr_sel != 3'd0) rf[wr_sel] <= wr_data;
          pc       <= (op == OP_JAL) ? target : npc;
          retired  <= 1'b1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: program table plus corner-case sequences.
module tb_mips_mc_core;

  localparam logic [15:0] HALT = 16'hE000;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retired, halted;
  logic [12:0] imem_addr, PC_current;
  logic [15:0] imem_rdata, current_instr;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;

  logic        i4_req, i4_ack, d4_req, d4_we, d4_ack, ret4, halt4;
  logic [3:0]  i4_addr, pc4;
  logic [15:0] i4_rdata, ir4, d4_addr, d4_wdata, d4_rdata;

  mips_mc_core #(.DATA_W(16), .PC_W(13)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .current_instr(current_instr), .PC_current(PC_current), .retired(retired), .halted(halted)
  );

  // Narrow-PC instance running an endless stream of NOPs from a zero-wait memory
  mips_mc_core #(.DATA_W(16), .PC_W(4)) u4 (
    .clk(clk), .rst(rst),
    .imem_req(i4_req), .imem_addr(i4_addr), .imem_rdata(i4_rdata), .imem_ack(i4_ack),
    .dmem_req(d4_req), .dmem_we(d4_we), .dmem_addr(d4_addr), .dmem_wdata(d4_wdata),
    .dmem_rdata(d4_rdata), .dmem_ack(d4_ack),
    .current_instr(ir4), .PC_current(pc4), .retired(ret4), .halted(halt4)
  );

  assign i4_ack   = i4_req;
  assign i4_rdata = 16'h000F;
  assign d4_rdata = '0;
  assign d4_ack   = 1'b0;

  typedef struct {
    logic [15:0][15:0] prog;
    int id, dd;
    int ra, va, rb, vb;
    int pc, cyc, ret, gap, we;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] imem [8192];
  logic [15:0] dmem [256];
  int id_dly, dd_dly, icnt, dcnt;
  int cyc, viol;
  int pass_cnt, total_cnt;
  int st[16];
  logic        pi_req, pd_req, pd_we;
  logic [12:0] pi_addr;
  logic [15:0] pd_addr, pd_wdata;

  function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int f);
    return {3'd0, 3'(rs), 3'(rt), 3'(rd), 4'(f)};
  endfunction
  function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {3'(op), 3'(rs), 3'(rt), 7'(imm)};
  endfunction
  function automatic logic [15:0] enc_j(input int op, input int t);
    return {3'(op), 13'(t)};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else pass_cnt++;
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Wait-stated memory models: ack after a programmable number of request cycles
  always @(negedge clk) begin
    if (imem_req) begin
      if (icnt == id_dly) begin imem_ack = 1'b1; icnt = 0; end
      else begin imem_ack = 1'b0; icnt++; end
    end else begin
      imem_ack = 1'b0; icnt = 0;
    end
    imem_rdata = imem[imem_addr];
    if (dmem_req) begin
      if (dcnt == dd_dly) begin dmem_ack = 1'b1; dcnt = 0; end
      else begin dmem_ack = 1'b0; dcnt++; end
    end else begin
      dmem_ack = 1'b0; dcnt = 0;
    end
    dmem_rdata = dmem[int'(dmem_addr) % 256];
  end

  // Store commits on the edge where the ack is sampled
  always @(posedge clk) begin
    if (rst && dmem_req && dmem_ack && dmem_we) dmem[int'(dmem_addr) % 256] = dmem_wdata;
  end

  // Handshake stability and protocol monitor
  always @(negedge clk) begin
    if (!rst) begin
      pi_req = 1'b0; pd_req = 1'b0;
    end else begin
      if (imem_addr != PC_current) viol++;
      if (dmem_we && !dmem_req) viol++;
      if (imem_req && pi_req && imem_addr != pi_addr) viol++;
      if (dmem_req && pd_req && (dmem_addr != pd_addr || dmem_wdata != pd_wdata || dmem_we != pd_we)) viol++;
      if (d4_req || d4_we || halt4 || i4_addr != pc4) viol++;
      pi_req = imem_req; pi_addr = imem_addr;
      pd_req = dmem_req; pd_addr = dmem_addr; pd_wdata = dmem_wdata; pd_we = dmem_we;
    end
  end

  task automatic load_prog(input logic [15:0][15:0] p);
    for (int k = 0; k < 8192; k++) imem[k] = HALT;
    for (int k = 0; k < 16; k++) imem[k] = p[k];
    for (int k = 0; k < 256; k++) dmem[k] = '0;
  endtask

  task automatic set_exp(input int i, input int id, input int dd, input int ra, input int va,
                         input int rb, input int vb, input int pcx, input int cy,
                         input int rt, input int gp, input int we);
    vecs[i].id = id; vecs[i].dd = dd; vecs[i].ra = ra; vecs[i].va = va;
    vecs[i].rb = rb; vecs[i].vb = vb; vecs[i].pc = pcx; vecs[i].cyc = cy;
    vecs[i].ret = rt; vecs[i].gap = gp; vecs[i].we = we;
  endtask

  task automatic run_vec(input int i);
    int start, nret, wec, halt_cyc, gap;
    bit done;
    rst = 1'b0;
    id_dly = vecs[i].id; dd_dly = vecs[i].dd;
    load_prog(vecs[i].prog);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start = -1; nret = 0; wec = 0; done = 1'b0; halt_cyc = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (start < 0 && imem_req) start = cyc;
      if (retired) begin
        if (nret < 16) st[nret] = cyc;
        nret++;
      end
      if (dmem_we) wec++;
      if (halted) begin done = 1'b1; halt_cyc = cyc; end
    end
    gap = (nret >= 3) ? st[2] - st[1] : -1;
    chk($sformatf("T%0d halted", i), longint'(done), 1);
    chk($sformatf("T%0d cycles", i), halt_cyc - start, vecs[i].cyc);
    chk($sformatf("T%0d retires", i), nret, vecs[i].ret);
    chk($sformatf("T%0d instr3 cycles", i), gap, vecs[i].gap);
    chk($sformatf("T%0d pc", i), longint'(PC_current), vecs[i].pc);
    chk($sformatf("T%0d r%0d", i, vecs[i].ra), longint'(dut.rf[vecs[i].ra]), vecs[i].va);
    chk($sformatf("T%0d r%0d", i, vecs[i].rb), longint'(dut.rf[vecs[i].rb]), vecs[i].vb);
    chk($sformatf("T%0d store cycles", i), wec, vecs[i].we);
  endtask

  initial begin
    logic [15:0][15:0] p;
    int n;
    bit found;
    pass_cnt = 0; total_cnt = 0; viol = 0; cyc = 0;
    id_dly = 0; dd_dly = 0; icnt = 0; dcnt = 0;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset imem_req", longint'(imem_req), 0);
    chk("reset dmem_req", longint'(dmem_req), 0);
    chk("reset pc", longint'(PC_current), 0);
    chk("reset ir", longint'(current_instr), 0);
    chk("reset retired", longint'(retired), 0);
    chk("reset halted", longint'(halted), 0);

    // T0: addi/addi/add/halt, zero wait
    for (int i = 0; i < 6; i++) vecs[i].prog = {16{HALT}};
    vecs[0].prog[0] = enc_i(1, 0, 1, 5);
    vecs[0].prog[1] = enc_i(1, 0, 2, -3);
    vecs[0].prog[2] = enc_r(1, 2, 3, 0);
    set_exp(0, 0, 0, 3, 2, 1, 5, 3, 15, 4, 4, 0);
    // T1: same program, two imem wait cycles per fetch
    vecs[1].prog = vecs[0].prog;
    set_exp(1, 2, 0, 3, 2, 2, 16'hFFFD, 3, 23, 4, 6, 0);
    // T2: sw then lw through a three-wait data memory
    vecs[2].prog[0] = enc_i(1, 0, 1, 5);
    vecs[2].prog[1] = enc_i(3, 0, 1, 4);
    vecs[2].prog[2] = enc_i(2, 0, 4, 4);
    set_exp(2, 0, 3, 4, 5, 1, 5, 3, 22, 4, 8, 4);
    // T3: jal to 0x0A, jr r7 back to 3, slt -1 < 1
    vecs[3].prog[0] = enc_i(1, 0, 1, -1);
    vecs[3].prog[1] = enc_i(1, 0, 2, 1);
    vecs[3].prog[2] = enc_j(6, 10);
    vecs[3].prog[3] = enc_r(1, 2, 5, 4);
    vecs[3].prog[10] = enc_r(7, 0, 0, 5);
    set_exp(3, 0, 0, 7, 3, 5, 1, 4, 22, 6, 4, 0);
    // T4: and, beq not taken, or
    vecs[4].prog[0] = enc_i(1, 0, 1, 12);
    vecs[4].prog[1] = enc_i(1, 0, 2, 10);
    vecs[4].prog[2] = enc_r(1, 2, 4, 2);
    vecs[4].prog[3] = enc_i(4, 1, 2, 3);
    vecs[4].prog[4] = enc_r(1, 2, 5, 3);
    set_exp(4, 0, 0, 4, 8, 5, 14, 5, 22, 6, 4, 0);
    // T5: sub wraps, beq taken skips, r0 write ignored, undefined funct is a NOP
    vecs[5].prog[0] = enc_i(1, 0, 1, 7);
    vecs[5].prog[1] = enc_r(0, 1, 3, 1);
    vecs[5].prog[2] = enc_i(4, 1, 1, 2);
    vecs[5].prog[3] = enc_i(1, 0, 6, 1);
    vecs[5].prog[5] = enc_i(1, 0, 0, 9);
    vecs[5].prog[6] = enc_r(1, 1, 6, 15);
    set_exp(5, 0, 0, 3, 16'hFFF9, 6, 0, 7, 22, 6, 3, 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // beq r0,r0,-1 at PC 0 loops on itself
    rst = 1'b0; id_dly = 0; dd_dly = 0;
    p = {16{HALT}};
    p[0] = enc_i(4, 0, 0, -1);
    load_prog(p);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 2; c++) begin
      @(negedge clk);
      if (retired) begin st[n] = cyc; n++; end
    end
    chk("selfloop retires", n, 2);
    chk("selfloop pc", longint'(PC_current), 0);
    chk("selfloop imem_addr", longint'(imem_addr), 0);
    chk("selfloop cycles", st[1] - st[0], 3);

    // PC_W=4 instance: the sixteenth NOP wraps PC from 15 to 0
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 16; c++) begin
      @(negedge clk);
      if (ret4) begin
        n++;
        if (n == 15) chk("wrap pc15", longint'(pc4), 15);
        if (n == 16) chk("wrap pc0", longint'(pc4), 0);
      end
    end
    chk("wrap retires", n, 16);

    // Reset during a wait-stated store abandons it
    rst = 1'b0; id_dly = 0; dd_dly = 5;
    p = {16{HALT}};
    p[0] = enc_i(1, 0, 1, 5);
    p[1] = enc_i(3, 0, 1, 4);
    load_prog(p);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (dmem_req) found = 1'b1;
    end
    chk("midreset store req seen", longint'(found), 1);
    chk("midreset store we", longint'(dmem_we), 1);
    #1 rst = 1'b0;
    #1;
    chk("midreset dmem_req", longint'(dmem_req), 0);
    chk("midreset dmem_we", longint'(dmem_we), 0);
    chk("midreset imem_req", longint'(imem_req), 0);
    chk("midreset r1", longint'(dut.rf[1]), 0);
    chk("midreset mem4", longint'(dmem[4]), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset pc", longint'(PC_current), 0);
    chk("midreset ir", longint'(current_instr), 0);
    rst = 1'b0;
    @(negedge clk);

    chk("handshake protocol", viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mips_mc_core.md
# mips_mc_core

Parametrised multi-cycle successor to the 16-bit single-cycle MIPS datapath. Executes the same 16-bit, 8-register instruction format through a FETCH/DECODE/EXEC/MEM/WB state machine with configurable data and PC widths. Instruction and data memories sit outside the core behind req/ack handshakes, so wait-stated or shared memories are supported. A HALT instruction and a retire pulse are provided for the bench and the system controller.

## Interface
- DATA_W, 16, register/ALU/data-bus width; legal range 16..32.
- PC_W, 13, PC and instruction-address width; legal range 4..13.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address; always equal to PC_current.
- imem_rdata  in  16  instruction word, sampled when imem_ack=1.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; 0 whenever dmem_req=0.
- dmem_addr  out  DATA_W  effective address.
- dmem_wdata  out  DATA_W  store data (rt).
- dmem_rdata  in  DATA_W  load data, sampled when dmem_ack=1.
- dmem_ack  in  1  data access complete.
- current_instr  out  16  instruction register (IR).
- PC_current  out  PC_W  PC register.
- retired  out  1  one-cycle pulse on the final cycle of each instruction.
- halted  out  1  core is in HALT.

## Operation
- Fields: opcode[15:13], rs[12:10], rt[9:7], rd[6:4], funct[3:0], imm[6:0]; imm is sign-extended to DATA_W; the jump target is instr[12:0] truncated to PC_W.
- Register file: 8 × DATA_W; r0 reads 0 and ignores writes.
- Opcodes:
  - 0 R-type, funct: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed, result 1/0), 5 jr (PC ← rs[PC_W-1:0]). Any other funct is a NOP with no write.
  - 1 addi: rt ← rs + imm.
  - 2 lw: rt ← mem[rs + imm].
  - 3 sw: mem[rs + imm] ← rt.
  - 4 beq: if rs == rt, PC ← PC + 1 + imm.
  - 5 j: PC ← target.
  - 6 jal: r7 ← zero-extended PC + 1, then PC ← target.
  - 7 halt.
- Arithmetic: all arithmetic wraps modulo 2^DATA_W; PC arithmetic wraps modulo 2^PC_W.
- States:
  - FETCH: imem_req=1; on ack, IR ← imem_rdata, NPC ← PC + 1, go to DECODE.
  - DECODE: A ← reg[rs], B ← reg[rt], go to EXEC.
  - EXEC: ALU result latched.
    - beq, j, jr: PC updated, retired=1, go to FETCH.
    - halt: retired=1, go to HALT.
    - lw, sw: go to MEM.
    - All others: go to WB.
  - MEM: dmem_req=1; on ack, lw latches MDR and goes to WB; sw sets PC ← NPC, retired=1, goes to FETCH.
  - WB: register write (rd for R-type, rt for addi/lw, r7 for jal); PC ← NPC, or target for jal; retired=1; go to FETCH.
  - HALT: absorbing. All requests are 0, halted=1. Only reset exits.
- NOP R-type takes the WB path with the write suppressed.

## Timing
- Reset (rst=0), applied asynchronously:
  - PC=0, IR=0, all registers 0, state=FETCH, retired=0, halted=0.
  - imem_req and dmem_req are forced 0 while rst=0.
  - The first fetch request appears in the first cycle after rst is released.
- Handshake:
  - req rises on state entry and holds with stable address/data until the rising edge where ack=1 is sampled.
  - ack may be high in the same cycle as req (zero-wait). req drops in the following cycle.
  - ack with req=0 is ignored.
- Cycle counts at zero wait:
  - beq/j/jr/halt: 3.
  - R-type/addi/jal/sw: 4.
  - lw: 5.
  - Each wait cycle adds one.
- Reset mid-transaction: requests drop immediately and the transaction is abandoned. No register, PC or memory-visible state is committed.
- A write to rX in WB is visible to the DECODE of the next instruction. No forwarding is needed.
- beq with rs == rt == r0 is always taken; jr r0 jumps to 0.

## Test plan
- Reset then zero-wait memories running `addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt` -> r3=2, PC_current=3, halted=1; 4 retired pulses; total 15 cycles after reset release.
- Same program with imem_ack delayed 2 cycles per fetch -> same results; each instruction takes +2 cycles; imem_addr is stable throughout each request.
- `sw r1,4(r0)` then `lw r4,4(r0)` with dmem_ack delayed 3 cycles -> dmem_we=1 only during the store request; r4=5; the lw takes 8 cycles.
- Branch and wrap: beq taken with imm=-1 at PC=0 -> PC=0 (self-loop). With PC_W=4 and PC=15, a non-branch wraps PC to 0.
- jal at PC=2 with target 0x0A -> r7=3, PC=0x0A. Then jr r7 -> PC=3. slt with r1=-1, r2=1 -> 1.
- Assert rst low while dmem_req=1 for a store -> dmem_req=0 in the same cycle. After release, PC=0, IR=0, and the stored value is not written.
